// File: rtl/object_slot_scheduler.sv
// Slot scheduler for rectangle-object drawers: spawn/kill bookkeeping plus a
// one-slot-per-clock velocity step once per frame.
module object_slot_scheduler #(
  parameter int NUM_SLOTS = 4,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int OBJ_W     = 32,
  parameter int OBJ_H     = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              startOfFrame,
  input  logic                              spawnReq,
  input  logic signed [10:0]                spawnX,
  input  logic signed [10:0]                spawnY,
  input  logic signed [3:0]                 spawnVX,
  input  logic signed [3:0]                 spawnVY,
  output logic                              spawnAck,
  output logic [$clog2(NUM_SLOTS)-1:0]      spawnSlot,
  input  logic                              killReq,
  input  logic [$clog2(NUM_SLOTS)-1:0]      killSlot,
  output logic [NUM_SLOTS-1:0]              slotEnable,
  output logic signed [NUM_SLOTS*11-1:0]    slotTopLeftX,
  output logic signed [NUM_SLOTS*11-1:0]    slotTopLeftY,
  output logic                              busy,
  output logic                              full
);

  localparam int SW = $clog2(NUM_SLOTS);

  // Off-screen limits in the 12-bit signed domain of the step arithmetic.
  localparam logic signed [11:0] LIM_L = 12'(-OBJ_W);
  localparam logic signed [11:0] LIM_T = 12'(-OBJ_H);
  localparam logic signed [11:0] LIM_R = 12'(SCREEN_W);
  localparam logic signed [11:0] LIM_B = 12'(SCREEN_H);

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t                state;
  state_t                state_nx;
  logic [SW-1:0]         idx;
  logic [SW-1:0]         idx_nx;

  logic [NUM_SLOTS-1:0]  en;
  logic [NUM_SLOTS-1:0]  en_nx;
  logic signed [10:0]    pos_x    [NUM_SLOTS];
  logic signed [10:0]    pos_y    [NUM_SLOTS];
  logic signed [10:0]    pos_x_nx [NUM_SLOTS];
  logic signed [10:0]    pos_y_nx [NUM_SLOTS];
  logic signed [3:0]     vel_x    [NUM_SLOTS];
  logic signed [3:0]     vel_y    [NUM_SLOTS];
  logic signed [3:0]     vel_x_nx [NUM_SLOTS];
  logic signed [3:0]     vel_y_nx [NUM_SLOTS];

  logic                  free_found;
  logic [SW-1:0]         free_slot;
  logic                  grant;
  logic signed [11:0]    nx;
  logic signed [11:0]    ny;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      IDLE: begin
        if (startOfFrame) begin
          state_nx = UPDATE;
          idx_nx   = '0;
        end
      end
      UPDATE: begin
        if (idx == SW'(NUM_SLOTS - 1)) begin
          state_nx = IDLE;
          idx_nx   = '0;
        end else begin
          idx_nx = idx + SW'(1);
        end
      end
    endcase
  end

  always_comb begin
    free_found = 1'b0;
    free_slot  = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!en[i] && !free_found) begin
        free_found = 1'b1;
        free_slot  = SW'(i);
      end
    end
  end

  // The !spawnAck term keeps a still-held request from being granted twice.
  assign grant = (state == IDLE) && !startOfFrame && spawnReq && !full &&
                 free_found && !spawnAck;

  // Order matters: frame step, then kill (wins over the step), then spawn
  // (its slot was free beforehand, so a kill aimed at it is a no-op).
  always_comb begin
    en_nx    = en;
    pos_x_nx = pos_x;
    pos_y_nx = pos_y;
    vel_x_nx = vel_x;
    vel_y_nx = vel_y;
    nx       = '0;
    ny       = '0;

    if (state == UPDATE && en[idx]) begin
      nx = {pos_x[idx][10], pos_x[idx]} + {{8{vel_x[idx][3]}}, vel_x[idx]};
      ny = {pos_y[idx][10], pos_y[idx]} + {{8{vel_y[idx][3]}}, vel_y[idx]};
      pos_x_nx[idx] = nx[10:0];
      pos_y_nx[idx] = ny[10:0];
      if (nx <= LIM_L || nx >= LIM_R || ny <= LIM_T || ny >= LIM_B)
        en_nx[idx] = 1'b0;
    end

    if (killReq)
      en_nx[killSlot] = 1'b0;

    if (grant) begin
      en_nx[free_slot]    = 1'b1;
      pos_x_nx[free_slot] = spawnX;
      pos_y_nx[free_slot] = spawnY;
      vel_x_nx[free_slot] = spawnVX;
      vel_y_nx[free_slot] = spawnVY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en        <= '0;
      pos_x     <= '{default: '0};
      pos_y     <= '{default: '0};
      vel_x     <= '{default: '0};
      vel_y     <= '{default: '0};
      spawnAck  <= 1'b0;
      spawnSlot <= '0;
      full      <= 1'b0;
    end else begin
      en        <= en_nx;
      pos_x     <= pos_x_nx;
      pos_y     <= pos_y_nx;
      vel_x     <= vel_x_nx;
      vel_y     <= vel_y_nx;
      spawnAck  <= grant;
      spawnSlot <= grant ? free_slot : '0;
      full      <= &en_nx;
    end
  end

  assign slotEnable = en;
  assign busy       = (state == UPDATE);

  always_comb begin
    slotTopLeftX = '0;
    slotTopLeftY = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      slotTopLeftX[11*i +: 11] = pos_x[i];
      slotTopLeftY[11*i +: 11] = pos_y[i];
    end
  end

endmodule
